// File: rtl/gf2_pkg.sv
// Shared types and helpers for the sequential GF(2) polynomial divider.
// Widths here describe the reference N=32 build; modules derive their own from N.
package gf2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEFAULT = 32;
  localparam int QW        = 2 * N_DEFAULT - 1;
  localparam int RW        = N_DEFAULT - 1;
  localparam int CW        = $clog2(QW);

  // Index of the highest set bit; zero input maps to 0. Covers divisors up to 64 bits.
  function automatic int msb_index(input logic [63:0] value);
    int idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (value[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/gf2_deg_enc.sv
// Combinational priority encoder giving the degree of an N-bit polynomial.
// A zero polynomial encodes as degree 0.
module gf2_deg_enc
  import gf2_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0]         value,
  output logic [$clog2(N)-1:0] deg
);

  always_comb begin
    deg = ($clog2(N))'(msb_index(64'(value)));
  end

endmodule

// File: rtl/gf2_poly_div_seq.sv
// Sequential GF(2) polynomial long divider, one dividend bit per cycle, MSB first.
// Define GF2_DIV_ZERO_CHK_EN to add the div_zero port and the early exit on a zero divisor.
module gf2_poly_div_seq
  import gf2_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-2:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] quotient,
  output logic [N-2:0]   remainder,
  output logic           busy
`ifdef GF2_DIV_ZERO_CHK_EN
  ,
  output logic           div_zero
`endif
);

  localparam int DW   = 2 * N - 1;
  localparam int CNTW = $clog2(DW);
  localparam int DEGW = $clog2(N);

  state_t state, state_nxt;

  logic [DW-1:0]   dd;
  logic [DW-1:0]   q;
  logic [N-2:0]    dv;
  logic [N-2:0]    r;
  logic [DEGW-1:0] deg;
  logic [DEGW-1:0] deg_in;
  logic [CNTW-1:0] count;

  logic            accept;
  logic            out_fire;
  logic [N-1:0]    t;
  logic            hit;
  logic [N-2:0]    r_step;

  gf2_deg_enc #(.N(N)) u_deg_enc (
    .value (divisor),
    .deg   (deg_in)
  );

  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // The divisor's leading term is implicit in deg, so only its lower N-1 bits are XORed in.
  always_comb begin
    t      = {r, dd[count]};
    hit    = t[deg];
    r_step = t[N-2:0] ^ (hit ? dv : '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef GF2_DIV_ZERO_CHK_EN
          state_nxt = (divisor == '0) ? DONE : BUSY;
`else
          state_nxt = BUSY;
`endif
        end
      end
      BUSY:    if (count == '0) state_nxt = DONE;
      DONE:    if (out_fire)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dd    <= '0;
      dv    <= '0;
      deg   <= '0;
      r     <= '0;
      q     <= '0;
      count <= '0;
    end else if (accept) begin
      dd    <= dividend;
      dv    <= divisor[N-2:0];
      deg   <= deg_in;
      r     <= '0;
      q     <= '0;
      count <= CNTW'(DW - 1);
    end else if (state == BUSY) begin
      r <= r_step;
      q <= {q[DW-2:0], hit};
      if (count != '0) count <= count - 1'b1;
    end
  end

`ifdef GF2_DIV_ZERO_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        div_zero <= 1'b0;
    else if (accept)   div_zero <= (divisor == '0);
    else if (out_fire) div_zero <= 1'b0;
  end
`endif

  assign quotient  = q;
  assign remainder = r;

endmodule

// File: tb/tb_gf2_poly_div_seq.sv
// Directed and round-trip checks for gf2_poly_div_seq at N=32.
module tb_gf2_poly_div_seq;
  import gf2_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] dividend;
  logic [31:0]   divisor;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] quotient;
  logic [RW-1:0] remainder;
  logic          busy;
`ifdef GF2_DIV_ZERO_CHK_EN
  logic          div_zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  gf2_poly_div_seq #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy)
`ifdef GF2_DIV_ZERO_CHK_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [QW-1:0] clmul(input logic [31:0] a, input logic [31:0] b);
    logic [QW-1:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) if (b[i]) p = p ^ (QW'(a) << i);
    return p;
  endfunction

  function automatic int poly_deg(input logic [31:0] v);
    int d;
    d = 0;
    for (int i = 0; i < 32; i++) if (v[i]) d = i;
    return d;
  endfunction

  // Presents one operation and returns #1 after the accepting edge; inputs are then scrambled.
  task automatic start_op(input logic [QW-1:0] dd, input logic [31:0] dv);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~dd;
    divisor  = ~dv;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) check("done_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("back_to_idle", 64'({in_ready, out_valid, busy}), 64'b100);
  endtask

  task automatic run_op(input string tag, input logic [QW-1:0] dd, input logic [31:0] dv,
                        input logic [QW-1:0] exp_q, input logic [RW-1:0] exp_r, input bit chk_lat);
    int lat;
    start_op(dd, dv);
    wait_done(lat);
    if (chk_lat) check({tag, "_latency"}, 64'(lat), 64'd63);
    check({tag, "_q"}, 64'(quotient), 64'(exp_q));
    check({tag, "_r"}, 64'(remainder), 64'(exp_r));
    release_out();
  endtask

  initial begin
    logic [QW-1:0] d_rand;
    logic [31:0]   a, b, c;
    int            lat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    check("reset_state", 64'({in_ready, out_valid, busy}), 64'b100);
    check("reset_q", 64'(quotient), 64'd0);
    check("reset_r", 64'(remainder), 64'd0);
    #11;
    rst_n = 1'b1;

    run_op("f_div_3",  QW'(64'hF), 32'h3, QW'(64'h5), '0, 1'b1);
    run_op("f_div_5",  QW'(64'hF), 32'h5, QW'(64'h3), '0, 1'b1);
    run_op("1_div_3",  QW'(64'h1), 32'h3, '0, RW'(32'h1), 1'b0);
    run_op("x62_div_x31", QW'(64'h4000_0000_0000_0000), 32'h8000_0000,
           QW'(64'h8000_0000), '0, 1'b1);

    d_rand = QW'(64'h5A3C_96E1_0F7B_D248);
    run_op("div_by_1", d_rand, 32'h1, d_rand, '0, 1'b0);

`ifdef GF2_DIV_ZERO_CHK_EN
    start_op(d_rand, 32'h0);
    check("dz_valid", 64'(out_valid), 64'd1);
    check("dz_flag", 64'(div_zero), 64'd1);
    check("dz_q", 64'(quotient), 64'd0);
    check("dz_r", 64'(remainder), 64'd0);
    release_out();
    check("dz_flag_clear", 64'(div_zero), 64'd0);
`else
    run_op("div_by_0", d_rand, 32'h0, d_rand, d_rand[RW-1:0], 1'b1);
`endif

    // Backpressure: results hold and new requests are ignored while out_ready is low.
    start_op(QW'(64'hF), 32'h3);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = QW'({$urandom, $urandom});
      divisor  = $urandom | 32'h1;
      @(posedge clk);
      #1;
      check("bp_hold", 64'({in_ready, out_valid, busy}), 64'b010);
      check("bp_q", 64'(quotient), 64'h5);
      check("bp_r", 64'(remainder), 64'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_release_no_accept", 64'({in_ready, out_valid, busy}), 64'b100);
    @(posedge clk);
    #1;
    check("bp_still_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of an operation (count has dropped to 20).
    start_op(d_rand, 32'h3);
    repeat (42) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_state", 64'({in_ready, out_valid, busy}), 64'b100);
    check("midrst_q", 64'(quotient), 64'd0);
    check("midrst_r", 64'(remainder), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", QW'(64'hF), 32'h5, QW'(64'h3), '0, 1'b1);

    // Round trip: (a*b ^ c) / b with deg(c) < deg(b) gives quotient a, remainder c.
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      if (i < 20) b = b >> (i + 8);
      if (b == 0) b = 32'h1;
      c = (poly_deg(b) == 0) ? 32'h0 : ($urandom & ((32'h1 << poly_deg(b)) - 32'h1));
      run_op("round_trip", clmul(a, b) ^ QW'(c), b, QW'(a), c[RW-1:0], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
